instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the synchronous program ROM (PMEM). It generates the byte-address fetch stream into the ROM's 1-cycle-latency read port and captures the returned words. It presents them with their PC to decode through a valid/ready handshake. A 2-entry output buffer absorbs decode back-pressure, and a same-cycle redirect port serves branches and jumps.

---
 rtl/instr_fetch_if.sv | 39 +++
 rtl/instr_fetch.sv | 85 ++++++++
 tb/tb_instr_fetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM read port, redirect port and the decode-side valid/ready handshake.
// The fetch stage is the master; the ROM/decode environment sits on the slave side.
interface instr_fetch_if #(
  parameter int PC_W = 10
);
  logic            fetch_en;
  logic            redirect_c0;
  logic [PC_W-1:0] redirect_pc_c0;
  logic [PC_W-1:0] pc_read_c0;
  logic [31:0]     instr_reg_c1;
  logic [31:0]     instr_c2;
  logic [PC_W-1:0] pc_c2;
  logic            valid_c2;
  logic            ready_c2;

  modport master (
    input  fetch_en,
    input  redirect_c0,
    input  redirect_pc_c0,
    output pc_read_c0,
    input  instr_reg_c1,
    output instr_c2,
    output pc_c2,
    output valid_c2,
    input  ready_c2
  );

  modport slave (
    output fetch_en,
    output redirect_c0,
    output redirect_pc_c0,
    input  pc_read_c0,
    output instr_reg_c1,
    input  instr_c2,
    input  pc_c2,
    input  valid_c2,
    output ready_c2
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the 1-cycle-latency program ROM and buffers returned
// words in a 2-entry FIFO toward decode, with a same-cycle redirect for branches/jumps.
module instr_fetch #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  logic [PC_W-1:0] pc_q;
  logic            inflight_q;
  logic [PC_W-1:0] inflight_pc_q;
  logic [1:0]      count_q;
  logic [31:0]     buf_instr_q [2];
  logic [PC_W-1:0] buf_pc_q    [2];

  logic            pop;
  logic            push;
  logic            issue;
  logic            start_fetch;
  logic [2:0]      occupancy;
  logic [PC_W-1:0] redirect_target;
  logic [PC_W-1:0] fetch_pc;

  assign redirect_target = {bus.redirect_pc_c0[PC_W-1:2], 2'b00};
  assign fetch_pc        = bus.redirect_c0 ? redirect_target : pc_q;
  assign bus.pc_read_c0  = fetch_pc;

  assign bus.valid_c2 = (count_q != 2'd0);
  assign pop          = bus.valid_c2 & bus.ready_c2;
  assign push         = inflight_q & ~bus.redirect_c0;

  // Only issue if the return next cycle is guaranteed a free slot, so the buffer never overflows.
  assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue       = bus.fetch_en & (occupancy <= 3'd1);
  assign start_fetch = bus.redirect_c0 ? bus.fetch_en : issue;

  // Masking with valid keeps stale buffer contents invisible, including right after reset.
  assign bus.instr_c2 = bus.valid_c2 ? buf_instr_q[0] : '0;
  assign bus.pc_c2    = bus.valid_c2 ? buf_pc_q[0]    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (start_fetch) begin
      inflight_q    <= 1'b1;
      inflight_pc_q <= fetch_pc;
      pc_q          <= fetch_pc + PC_W'(4);
    end else begin
      inflight_q <= 1'b0;
      if (bus.redirect_c0) begin
        pc_q <= redirect_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
    end else if (bus.redirect_c0) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down, a push lands behind the survivors.
  always_ff @(posedge clk) begin
    if (push) begin
      if (pop || (count_q == 2'd0)) begin
        buf_instr_q[0] <= bus.instr_reg_c1;
        buf_pc_q[0]    <= inflight_pc_q;
      end else begin
        buf_instr_q[1] <= bus.instr_reg_c1;
        buf_pc_q[1]    <= inflight_pc_q;
      end
    end else if (pop) begin
      buf_instr_q[0] <= buf_instr_q[1];
      buf_pc_q[0]    <= buf_pc_q[1];
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with a behavioural synchronous ROM.
module tb_instr_fetch;
  localparam int PC_W = 10;

  typedef struct {
    logic            fetch_en;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            ready;
    logic            exp_valid;
    logic [PC_W-1:0] exp_pc;
    logic [PC_W-1:0] exp_pc_read;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  instr_fetch_if #(.PC_W(PC_W)) bus ();

  instr_fetch #(.PC_W(PC_W), .RESET_PC(10'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [PC_W-1:0] a);
    case (a)
      10'h000: return 32'h0000_0113;
      10'h004: return 32'h0000_0413;
      10'h074: return 32'hff01_0113;
      default: return {12'hA5C, 10'b0, a};
    endcase
  endfunction

  always @(posedge clk) bus.instr_reg_c1 <= rom_word(bus.pc_read_c0);

  function automatic void add(input logic fe, input logic rd, input logic [PC_W-1:0] rpc,
                              input logic rdy, input logic ev, input logic [PC_W-1:0] epc,
                              input logic [PC_W-1:0] erd);
    vec_t v;
    v.fetch_en    = fe;
    v.redirect    = rd;
    v.redirect_pc = rpc;
    v.ready       = rdy;
    v.exp_valid   = ev;
    v.exp_pc      = epc;
    v.exp_pc_read = erd;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.fetch_en       = v.fetch_en;
    bus.redirect_c0    = v.redirect;
    bus.redirect_pc_c0 = v.redirect_pc;
    bus.ready_c2       = v.ready;
  endtask

  // Each row is applied just after a falling edge and checked 1ns later, before the rising edge.
  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d valid", i), {31'b0, bus.valid_c2}, {31'b0, vecs[i].exp_valid});
      checkOutput($sformatf("row%0d pc_read", i), 32'(bus.pc_read_c0), 32'(vecs[i].exp_pc_read));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("row%0d pc_c2", i), 32'(bus.pc_c2), 32'(vecs[i].exp_pc));
        checkOutput($sformatf("row%0d instr", i), bus.instr_c2, rom_word(vecs[i].exp_pc));
      end
      @(negedge clk);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " valid"}, {31'b0, bus.valid_c2}, 32'd0);
    checkOutput({tag, " instr"}, bus.instr_c2, 32'd0);
    checkOutput({tag, " pc_c2"}, 32'(bus.pc_c2), 32'd0);
    checkOutput({tag, " pc_read"}, 32'(bus.pc_read_c0), 32'd0);
  endtask

  initial begin
    bus.fetch_en       = 1'b0;
    bus.redirect_c0    = 1'b0;
    bus.redirect_pc_c0 = '0;
    bus.ready_c2       = 1'b0;

    // fe  rd  rpc     rdy  valid  pc      pc_read
    add(1, 0, 10'h000, 1,   0,     10'h000, 10'h000);  // 0  first issue
    add(1, 0, 10'h000, 1,   0,     10'h000, 10'h004);  // 1
    add(1, 0, 10'h000, 1,   1,     10'h000, 10'h008);  // 2  first valid
    add(1, 0, 10'h000, 1,   1,     10'h004, 10'h00C);  // 3
    add(1, 0, 10'h000, 1,   1,     10'h008, 10'h010);  // 4
    add(1, 0, 10'h000, 1,   1,     10'h00C, 10'h014);  // 5
    for (int k = 0; k < 5; k++)
      add(1, 0, 10'h000, 0, 1,     10'h010, 10'h018);  // 6-10 stall, head stable
    add(1, 0, 10'h000, 1,   1,     10'h010, 10'h018);  // 11 resume
    add(1, 0, 10'h000, 1,   1,     10'h014, 10'h01C);  // 12
    add(1, 0, 10'h000, 1,   1,     10'h018, 10'h020);  // 13
    add(1, 0, 10'h000, 0,   1,     10'h01C, 10'h024);  // 14 fill to 2
    add(1, 0, 10'h000, 0,   1,     10'h01C, 10'h024);  // 15 full
    add(1, 1, 10'h074, 1,   1,     10'h01C, 10'h074);  // 16 redirect while full
    add(1, 0, 10'h000, 1,   0,     10'h000, 10'h078);  // 17
    add(1, 0, 10'h000, 1,   1,     10'h074, 10'h07C);  // 18 target arrives
    add(1, 0, 10'h000, 1,   1,     10'h078, 10'h080);  // 19
    add(1, 1, 10'h010, 1,   1,     10'h07C, 10'h010);  // 20 redirect mid-stream
    add(1, 1, 10'h022, 1,   0,     10'h000, 10'h020);  // 21 back-to-back, low bits ignored
    add(1, 0, 10'h000, 1,   0,     10'h000, 10'h024);  // 22
    add(1, 0, 10'h000, 1,   1,     10'h020, 10'h028);  // 23 only 0x020 stream
    add(1, 0, 10'h000, 1,   1,     10'h024, 10'h02C);  // 24
    add(0, 0, 10'h000, 0,   1,     10'h028, 10'h030);  // 25 fetch_en drops
    add(0, 0, 10'h000, 1,   1,     10'h028, 10'h030);  // 26
    add(0, 0, 10'h000, 1,   1,     10'h02C, 10'h030);  // 27 the one in-flight push
    add(0, 0, 10'h000, 1,   0,     10'h000, 10'h030);  // 28 drained
    add(0, 1, 10'h3F8, 1,   0,     10'h000, 10'h3F8);  // 29 redirect without fetch
    add(0, 0, 10'h000, 1,   0,     10'h000, 10'h3F8);  // 30
    add(1, 0, 10'h000, 1,   0,     10'h000, 10'h3F8);  // 31
    add(1, 0, 10'h000, 1,   0,     10'h000, 10'h3FC);  // 32
    add(1, 0, 10'h000, 1,   1,     10'h3F8, 10'h000);  // 33 address wrap
    add(1, 0, 10'h000, 1,   1,     10'h3FC, 10'h004);  // 34
    add(1, 0, 10'h000, 1,   1,     10'h000, 10'h008);  // 35
    add(1, 0, 10'h000, 1,   1,     10'h004, 10'h00C);  // 36
    add(1, 0, 10'h000, 1,   1,     10'h008, 10'h010);  // 37

    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    runVectors(0, vecs.size() - 1);

    // Asynchronous reset in the middle of the high phase, away from any rising edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkResetState("async reset");
    @(negedge clk);
    rst = 1'b0;
    runVectors(0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
